// File: rtl/pixel_unpacker.sv
// Scanline FIFO word-to-pixel unpacker: prefetch in blanking, line-start realign, sticky underrun.
// Define PIXEL_UNPACKER_MSB_FIRST_EN to emit the first pixel of each word from its MSBs.
module pixel_unpacker #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_not_empty,
  output logic                   fifo_rd_en,
  input  logic                   de,
  input  logic                   line_start,
  input  logic                   underrun_clear,
  output logic [PIXEL_WIDTH-1:0] pixel,
  output logic                   pixel_valid,
  output logic                   underrun
);

  localparam int unsigned PPW   = DATA_WIDTH / PIXEL_WIDTH;
  localparam int unsigned IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PPW - 1);

  logic [DATA_WIDTH-1:0]  word_q;
  logic                   held_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   last_c;
  logic                   discard_c;
  logic [PIXEL_WIDTH-1:0] slot_c;

  assign last_c = (idx_q == LAST_IDX);

  // Pop when nothing is held, or when the last slot is consumed; never on a blanking line_start.
  assign fifo_rd_en = fifo_not_empty & ~reset
                    & (~held_q | (de & last_c))
                    & ~(line_start & ~de);

  assign discard_c = line_start & ~de & held_q & (idx_q != '0);

  // Slot mux; PPW need not be a power of two so unmatched indices fall to zero.
  always_comb begin
    slot_c = '0;
    for (int unsigned k = 0; k < PPW; k++) begin
      if (idx_q == IDX_W'(k)) begin
`ifdef PIXEL_UNPACKER_MSB_FIRST_EN
        slot_c = word_q[DATA_WIDTH-1-k*PIXEL_WIDTH -: PIXEL_WIDTH];
`else
        slot_c = word_q[k*PIXEL_WIDTH +: PIXEL_WIDTH];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q      <= '0;
      held_q      <= 1'b0;
      idx_q       <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (fifo_rd_en) begin
        word_q <= fifo_rd_data;
        held_q <= 1'b1;
        idx_q  <= '0;
      end else if (discard_c) begin
        held_q <= 1'b0;
        idx_q  <= '0;
      end else if (de && held_q) begin
        if (last_c) begin
          held_q <= 1'b0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end

      if (de) begin
        pixel       <= held_q ? slot_c : '0;
        pixel_valid <= 1'b1;
      end else begin
        pixel       <= '0;
        pixel_valid <= 1'b0;
      end

      // A new underrun outranks a clear in the same cycle.
      if (de && !held_q) begin
        underrun <= 1'b1;
      end else if (underrun_clear) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed scoreboard bench for pixel_unpacker (32-bit words, 8-bit pixels).
// Honours PIXEL_UNPACKER_MSB_FIRST_EN for the expected slot order.
module tb_pixel_unpacker;

  typedef struct {
    logic [7:0] pix;
    logic       vld;
    logic       unr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_not_empty = 1'b0;
  logic        fifo_rd_en;
  logic        de = 1'b0;
  logic        line_start = 1'b0;
  logic        underrun_clear = 1'b0;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        underrun;

  logic [31:0] fifo_q[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          pops_mark = 0;

  pixel_unpacker #(.DATA_WIDTH(32), .PIXEL_WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_not_empty (fifo_not_empty),
    .fifo_rd_en     (fifo_rd_en),
    .de             (de),
    .line_start     (line_start),
    .underrun_clear (underrun_clear),
    .pixel          (pixel),
    .pixel_valid    (pixel_valid),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] px(input logic [31:0] w, input int k);
`ifdef PIXEL_UNPACKER_MSB_FIRST_EN
    return w[31-8*k -: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  task automatic fifo_sync();
    fifo_not_empty = (fifo_q.size() != 0);
    fifo_rd_data   = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic fifo_push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_sync();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, pop the model FIFO after the edge, compare scoreboard head.
  task automatic step(input logic d, input logic ls, input logic clr,
                      input logic [7:0] ep, input logic ev, input logic eu, input string tag);
    exp_t e;
    logic popped;
    de = d; line_start = ls; underrun_clear = clr;
    e.pix = ep; e.vld = ev; e.unr = eu;
    sb.push_back(e);
    #1;
    popped = fifo_rd_en;
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    fifo_sync();
    e = sb.pop_front();
    check({tag, ".pixel"}, 32'(pixel), 32'(e.pix));
    check({tag, ".valid"}, 32'(pixel_valid), 32'(e.vld));
    check({tag, ".underrun"}, 32'(underrun), 32'(e.unr));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w0, w1, w2, w3;
    w0 = 32'h44332211;
    w1 = 32'h88776655;
    w2 = 32'hDDCCBBAA;
    w3 = 32'h0D0C0B0A;

    // Reset state, with words waiting in the FIFO.
    fifo_push(w0);
    fifo_push(w1);
    @(posedge clk);
    #1;
    check("rst.pixel", 32'(pixel), 32'h0);
    check("rst.valid", 32'(pixel_valid), 32'h0);
    check("rst.underrun", 32'(underrun), 32'h0);
    check("rst.rd_en", 32'(fifo_rd_en), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Prefetch in blanking, then 8 pixels with no bubble.
    pops_mark = pops;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "blank");
    check("prefetch_pops", 32'(pops - pops_mark), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, px(w0, i), 1'b1, 1'b0, "stream_w0");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, px(w1, i), 1'b1, 1'b0, "stream_w1");
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "stream_end");
    check("stream_pops", 32'(pops - pops_mark), 32'd2);

    // Underrun with a single word, then clear/set collision, then clear.
    fifo_push(w0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ur_blank");
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ur_blank");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, px(w0, i), 1'b1, 1'b0, "ur_word");
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "ur_empty0");
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "ur_empty1");
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "ur_sticky");
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "ur_collide");
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "ur_clear");
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ur_cleared");

    // Line realign: discard remainder of a partial word; line_start ignored when loaded or de high.
    fifo_push(w0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ra_prefetch");
    step(1'b1, 1'b0, 1'b0, px(w0, 0), 1'b1, 1'b0, "ra_p0");
    step(1'b1, 1'b0, 1'b0, px(w0, 1), 1'b1, 1'b0, "ra_p1");
    fifo_push(w2);
    pops_mark = pops;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ra_hold");
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "ra_discard");
    check("ra_no_pop", 32'(pops - pops_mark), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ra_refetch");
    check("ra_refetch_pop", 32'(pops - pops_mark), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "ra_ls_loaded");
    step(1'b1, 1'b1, 1'b0, px(w2, 0), 1'b1, 1'b0, "ra_ls_de");
    step(1'b1, 1'b0, 1'b0, px(w2, 1), 1'b1, 1'b0, "ra_n1");

    // Reset mid-line: outputs clear at once, next word starts at slot 0.
    fifo_push(w3);
    reset = 1'b1;
    #1;
    check("mid_rst.pixel", 32'(pixel), 32'h0);
    check("mid_rst.valid", 32'(pixel_valid), 32'h0);
    check("mid_rst.underrun", 32'(underrun), 32'h0);
    check("mid_rst.rd_en", 32'(fifo_rd_en), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "post_rst_prefetch");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, px(w3, i), 1'b1, 1'b0, "post_rst");
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "post_rst_end");
    check("fifo_drained", 32'(fifo_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
